// File: rtl/apb_slave_regfile.sv
// APB3/APB4 completer fronting a byte-strobed register file.
// Responses are fully registered and stretched by a fixed number of wait states.
module apb_slave_regfile #(
  parameter int ADDWIDTH    = 8,
  parameter int DATAWIDTH   = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [ADDWIDTH-1:0]    PADDR,
  input  logic [DATAWIDTH-1:0]   PWDATA,
  input  logic [DATAWIDTH/8-1:0] PSTRB,
  output logic                   PREADY,
  output logic [DATAWIDTH-1:0]   PRDATA,
  output logic                   PSLVERR
);

  localparam int NB = DATAWIDTH / 8;
  localparam int LW = $clog2(NB);
  localparam int IW = ADDWIDTH - LW;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   latch, enter_done, commit;

  logic [IW-1:0]          idx_q;
  logic                   wr_q;
  logic [DATAWIDTH-1:0]   wdata_q;
  logic [NB-1:0]          strb_q;

  logic                   pready_q, pslverr_q;
  logic [DATAWIDTH-1:0]   prdata_q;
  logic [DATAWIDTH-1:0]   mem [DEPTH];

  logic [IW-1:0]          idx_in, cur_idx;
  logic                   cur_wr, cur_in;
  logic [DATAWIDTH-1:0]   rd_word;

  function automatic logic in_range(input logic [IW-1:0] i);
    return 32'(i) < 32'(DEPTH);
  endfunction

  function automatic logic [DATAWIDTH-1:0] merge_bytes(
    input logic [DATAWIDTH-1:0] old_w,
    input logic [DATAWIDTH-1:0] new_w,
    input logic [NB-1:0]        strb
  );
    logic [DATAWIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++)
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    return res;
  endfunction

  // Low address bits only select a byte lane and are deliberately ignored.
  generate
    if (LW > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^PADDR[LW-1:0];
    end
  endgenerate

  assign idx_in = PADDR[ADDWIDTH-1:LW];

  // When the response is loaded straight out of IDLE the setup fields are
  // not latched yet, so take them from the bus for that one edge.
  always_comb begin
    cur_idx = idx_q;
    cur_wr  = wr_q;
    if (state_q == S_IDLE) begin
      cur_idx = idx_in;
      cur_wr  = PWRITE;
    end
    cur_in  = in_range(cur_idx);
    rd_word = '0;
    if (cur_in) rd_word = mem[cur_idx[MW-1:0]];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch      = 1'b0;
    enter_done = 1'b0;
    commit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (PENABLE) begin
          if (cnt_q <= 4'd1) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        commit  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= enter_done;
      if (enter_done) begin
        pslverr_q <= !cur_in;
        if (!cur_wr) prdata_q <= rd_word;
      end else begin
        pslverr_q <= 1'b0;
      end
    end
  end

  // Setup-phase capture
  always_ff @(posedge PCLK) begin
    if (latch) begin
      idx_q   <= idx_in;
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end
  end

  // Register file; writes land on the completion edge only
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && wr_q && in_range(idx_q)) begin
      mem[idx_q[MW-1:0]] <= merge_bytes(mem[idx_q[MW-1:0]], wdata_q, strb_q);
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule
